// File: rtl/sipo_byte_deserializer_pkg.sv
// Shared sizing constants for the PISO / SIPO / framing family of blocks.
package sipo_byte_deserializer_pkg;

  localparam int WIDTH_DEF     = 8;
  localparam int CNT_W_DEF     = $clog2(WIDTH_DEF);
  localparam bit LSB_FIRST_DEF = 1'b1;

  // Counter width for a given word size; never narrower than one bit.
  function automatic int cnt_width(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/sipo_byte_deserializer_if.sv
// Parallel word output bus: valid/ready handshake carrying one assembled word.
interface sipo_byte_deserializer_if #(
  parameter int WIDTH = sipo_byte_deserializer_pkg::WIDTH_DEF
);
  logic [WIDTH-1:0] data_out;
  logic             data_valid;
  logic             data_ready;

  modport master (output data_out, output data_valid, input  data_ready);
  modport slave  (input  data_out, input  data_valid, output data_ready);
endinterface

// File: rtl/sipo_byte_deserializer_hold.sv
// One-word valid/ready holding register; drops a completing word that finds
// the register still occupied and flags it on the sticky overrun output.
module word_hold_reg
  import sipo_byte_deserializer_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_load,
  input  logic [WIDTH-1:0]     i_word,
  input  logic                 ovr_clr,
  output logic                 overrun,
  sipo_byte_deserializer_if.master bus
);

  logic [WIDTH-1:0] r_data;
  logic             r_valid;
  logic             r_ovr;
  logic             w_xfer;
  logic             w_accept;
  logic             w_drop;

  assign w_xfer   = r_valid & bus.data_ready;
  // The register can take a new word if empty or emptying on this edge.
  assign w_accept = i_load & (~r_valid | bus.data_ready);
  assign w_drop   = i_load & r_valid & ~bus.data_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else if (w_accept) begin
      r_data  <= i_word;
      r_valid <= 1'b1;
    end else if (w_xfer) begin
      r_valid <= 1'b0;
    end
  end

  // Set has priority over clear so a coincident drop is never lost.
  always_ff @(posedge clk) begin
    if (rst)          r_ovr <= 1'b0;
    else if (w_drop)  r_ovr <= 1'b1;
    else if (ovr_clr) r_ovr <= 1'b0;
  end

  assign bus.data_out   = r_data;
  assign bus.data_valid = r_valid;
  assign overrun        = r_ovr;

endmodule

// File: rtl/sipo_byte_deserializer.sv
// Serial-to-parallel receive stage: shifts in one bit per strobe, hands each
// WIDTH-bit word to a holding register, and realigns on sync.
module sipo_byte_deserializer
  import sipo_byte_deserializer_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter bit LSB_FIRST = LSB_FIRST_DEF,
  localparam int CNT_W    = cnt_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             serial_in,
  input  logic             shift_in,
  input  logic             sync,
  input  logic             ovr_clr,
  output logic             overrun,
  output logic [CNT_W-1:0] bit_count,
  sipo_byte_deserializer_if.master bus
);

  logic [WIDTH-1:0] r_sr;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] w_src;
  logic [WIDTH-1:0] w_sr_next;
  logic             w_last;
  logic             w_complete;

  // A sync strobe starts a fresh word, so shift into an empty register.
  assign w_src = sync ? '0 : r_sr;

  generate
    if (LSB_FIRST) begin : g_lsb
      assign w_sr_next = {serial_in, w_src[WIDTH-1:1]};
    end else begin : g_msb
      assign w_sr_next = {w_src[WIDTH-2:0], serial_in};
    end
  endgenerate

  assign w_last     = (r_cnt == CNT_W'(WIDTH - 1));
  assign w_complete = shift_in & ~sync & w_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sr  <= '0;
      r_cnt <= '0;
    end else if (shift_in) begin
      r_sr <= w_sr_next;
      if (sync)        r_cnt <= CNT_W'(1);
      else if (w_last) r_cnt <= '0;
      else             r_cnt <= r_cnt + CNT_W'(1);
    end else if (sync) begin
      r_sr  <= '0;
      r_cnt <= '0;
    end
  end

  assign bit_count = r_cnt;

  word_hold_reg #(.WIDTH(WIDTH)) u_hold (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_complete),
    .i_word  (w_sr_next),
    .ovr_clr (ovr_clr),
    .overrun (overrun),
    .bus     (bus)
  );

endmodule

// File: tb/tb_sipo_byte_deserializer.sv
// Directed bench for sipo_byte_deserializer: LSB-first and MSB-first instances.
module tb_sipo_byte_deserializer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       serial_in = 1'b0;
  logic       shift_in = 1'b0;
  logic       sync = 1'b0;
  logic       ovr_clr = 1'b0;
  logic       ready = 1'b0;
  logic       ovr_a, ovr_b;
  logic [2:0] cnt_a, cnt_b;
  int         n_chk = 0;
  int         n_err = 0;

  sipo_byte_deserializer_if #(.WIDTH(8)) bus_a ();
  sipo_byte_deserializer_if #(.WIDTH(8)) bus_b ();
  assign bus_a.data_ready = ready;
  assign bus_b.data_ready = ready;

  sipo_byte_deserializer #(.WIDTH(8), .LSB_FIRST(1'b1)) u_dut_a (
    .clk(clk), .rst(rst), .serial_in(serial_in), .shift_in(shift_in),
    .sync(sync), .ovr_clr(ovr_clr), .overrun(ovr_a), .bit_count(cnt_a),
    .bus(bus_a)
  );

  sipo_byte_deserializer #(.WIDTH(8), .LSB_FIRST(1'b0)) u_dut_b (
    .clk(clk), .rst(rst), .serial_in(serial_in), .shift_in(shift_in),
    .sync(sync), .ovr_clr(ovr_clr), .overrun(ovr_b), .bit_count(cnt_b),
    .bus(bus_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    shift_in = 1'b0;
    tick();
  endtask

  task automatic send_bit(input logic b);
    serial_in = b;
    shift_in  = 1'b1;
    tick();
    shift_in  = 1'b0;
  endtask

  // LSB-first word on DUT A; optional random 0..3 cycle gaps with count checks.
  task automatic send_word(input logic [7:0] w, input bit gaps);
    for (int i = 0; i < 8; i++) begin
      if (gaps) begin
        int g = $urandom_range(0, 3);
        for (int k = 0; k < g; k++) begin
          idle();
          check("gap_cnt", 32'(cnt_a), 32'(i));
        end
      end
      check("step_cnt", 32'(cnt_a), 32'(i));
      send_bit(w[i]);
    end
  endtask

  initial begin
    tick();
    tick();
    check("rst_valid", 32'(bus_a.data_valid), 32'd0);
    check("rst_data",  32'(bus_a.data_out),   32'h00);
    check("rst_ovr",   32'(ovr_a),            32'd0);
    check("rst_cnt",   32'(cnt_a),            32'd0);
    rst = 1'b0;

    // Back-to-back strobes, consumer always ready.
    ready = 1'b1;
    send_word(8'hA5, 1'b0);
    check("a5_valid", 32'(bus_a.data_valid), 32'd1);
    check("a5_data",  32'(bus_a.data_out),   32'hA5);
    idle();
    check("a5_pulse", 32'(bus_a.data_valid), 32'd0);

    // Gapped strobes.
    send_word(8'h3C, 1'b1);
    check("3c_data",  32'(bus_a.data_out),   32'h3C);
    check("3c_valid", 32'(bus_a.data_valid), 32'd1);
    check("3c_cnt",   32'(cnt_a),            32'd0);
    idle();

    // Backpressure: second word dropped, overrun set.
    ready = 1'b0;
    send_word(8'h11, 1'b0);
    check("ovr_pre", 32'(ovr_a), 32'd0);
    send_word(8'h22, 1'b0);
    check("ovr_data",  32'(bus_a.data_out),   32'h11);
    check("ovr_valid", 32'(bus_a.data_valid), 32'd1);
    check("ovr_set",   32'(ovr_a),            32'd1);
    ready = 1'b1;
    idle();
    check("ovr_xfer",   32'(bus_a.data_valid), 32'd0);
    check("ovr_sticky", 32'(ovr_a),            32'd1);
    ovr_clr = 1'b1;
    idle();
    ovr_clr = 1'b0;
    check("ovr_clr", 32'(ovr_a), 32'd0);

    // Transfer and completion on the same edge.
    ready = 1'b0;
    send_word(8'h33, 1'b0);
    check("33_data", 32'(bus_a.data_out), 32'h33);
    begin
      logic [7:0] w44 = 8'h44;
      for (int i = 0; i < 7; i++) send_bit(w44[i]);
      ready = 1'b1;
      send_bit(w44[7]);
    end
    check("44_data",  32'(bus_a.data_out),   32'h44);
    check("44_valid", 32'(bus_a.data_valid), 32'd1);
    check("44_ovr",   32'(ovr_a),            32'd0);
    idle();
    check("44_xfer", 32'(bus_a.data_valid), 32'd0);

    // Sync with a strobe realigns onto the current bit.
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b1);
    check("pre_sync_cnt", 32'(cnt_a), 32'd3);
    sync = 1'b1;
    send_bit(1'b1);
    sync = 1'b0;
    check("sync_cnt", 32'(cnt_a), 32'd1);
    begin
      logic [7:0] w81 = 8'h81;
      for (int i = 1; i < 8; i++) send_bit(w81[i]);
    end
    check("81_data",  32'(bus_a.data_out),   32'h81);
    check("81_valid", 32'(bus_a.data_valid), 32'd1);
    idle();

    // Sync without a strobe clears the partial word and never completes one.
    for (int i = 0; i < 7; i++) send_bit(1'b0);
    check("pre_sync0_cnt", 32'(cnt_a), 32'd7);
    sync = 1'b1;
    idle();
    sync = 1'b0;
    check("sync0_cnt",   32'(cnt_a),            32'd0);
    check("sync0_valid", 32'(bus_a.data_valid), 32'd0);
    check("sync0_data",  32'(bus_a.data_out),   32'h81);

    // Reset mid-word with a held word.
    ready = 1'b0;
    send_word(8'hFF, 1'b0);
    check("ff_data", 32'(bus_a.data_out), 32'hFF);
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    check("ff_cnt", 32'(cnt_a), 32'd5);
    rst = 1'b1;
    idle();
    rst = 1'b0;
    check("rst2_data",  32'(bus_a.data_out),   32'h00);
    check("rst2_valid", 32'(bus_a.data_valid), 32'd0);
    check("rst2_ovr",   32'(ovr_a),            32'd0);
    check("rst2_cnt",   32'(cnt_a),            32'd0);
    ready = 1'b1;
    send_word(8'h5A, 1'b0);
    check("5a_data", 32'(bus_a.data_out), 32'h5A);
    idle();

    // MSB-first instance: 0,1,0,1,1,0,1,0 -> 0x5A. The same stream read
    // LSB-first is 0b01011010 as well.
    rst = 1'b1;
    idle();
    rst = 1'b0;
    begin
      logic [7:0] bits = 8'b0101_1010;
      for (int i = 0; i < 8; i++) begin
        check("msb_cnt", 32'(cnt_b), 32'(i));
        send_bit(bits[7-i]);
      end
    end
    check("msb_data",  32'(bus_b.data_out),   32'h5A);
    check("msb_valid", 32'(bus_b.data_valid), 32'd1);
    check("lsb_same",  32'(bus_a.data_out),   32'h5A);
    idle();
    check("msb_xfer", 32'(bus_b.data_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/sipo_byte_deserializer.md
Name: sipo_byte_deserializer

Overview:
Downstream receive stage for the 8-bit PISO serializer. It consumes the serializer's serial bit stream, one bit per qualified strobe, and reassembles each run of WIDTH bits into a parallel word. Completed words are presented on a valid/ready output with a one-word holding register. A sticky overrun flag reports words lost to backpressure. A sync input realigns the word boundary.

Parameters:
WIDTH, 8, bits per word; legal range 2..32.
LSB_FIRST, 1, 1 = first received bit lands in data_out[0], matching the PISO shift order; 0 = first bit lands in data_out[WIDTH-1].

Ports:
clk  input  1  single clock, rising edge
rst  input  1  synchronous, active-high reset
serial_in  input  1  serial data bit, sampled only when shift_in=1
shift_in  input  1  bit strobe; each high cycle consumes one bit
sync  input  1  word-boundary realign; discards any partial word
data_out  output  WIDTH  assembled word; stable while data_valid=1
data_valid  output  1  word available
data_ready  input  1  consumer accepts data_out at this edge when data_valid=1
overrun  output  1  sticky: a completed word was dropped
ovr_clr  input  1  clears overrun
bit_count  output  $clog2(WIDTH)  bits of the current partial word received

Behaviour:
- Interface: one clock (clk); reset (rst) is synchronous and active-high.
- Reset values: shift register 0, bit_count 0, data_out 0, data_valid 0, overrun 0. Reset mid-word discards the partial word. Reset also drops any held word.
- Shift, LSB_FIRST=1: sr <= {serial_in, sr[WIDTH-1:1]}.
- Shift, LSB_FIRST=0: sr <= {sr[WIDTH-2:0], serial_in}.
- Each shift_in=1 cycle increments bit_count. A shift with bit_count==WIDTH-1 completes a word and wraps bit_count to 0.
- Completion: the word including the current bit goes directly into the output register. data_valid rises on the edge of the WIDTH-th strobe, so it is visible the cycle after that strobe is presented.
- Handshake: transfer occurs on a rising edge with data_valid && data_ready. data_valid then clears unless a new word completes on the same edge. data_out is held unchanged while data_valid=1 and not transferred.
- Completion with data_valid=1 and data_ready=0:
  - the new word is dropped and the held word is kept;
  - overrun <= 1 and stays set until ovr_clr or rst.
- Completion with data_valid=1 and data_ready=1: the new word loads, data_valid stays 1, and there is no overrun.
- ovr_clr coincident with a new overrun event: the set wins and overrun=1.
- shift_in=0: sr, bit_count and serial_in sampling are all frozen. Arbitrary gaps between strobes are legal.
- sync=1 with shift_in=0: sr <= 0 and bit_count <= 0.
- sync=1 with shift_in=1: the current bit becomes bit 0 of a new word. bit_count <= 1 and sr holds only that bit.
- sync never affects data_out, data_valid or overrun. sync does not complete a word, even if bit_count==WIDTH-1.
- rst has priority over all other inputs.
- Throughput: one word per WIDTH strobes, with no dead cycles between words.

Decomposition:
- Shared package: WIDTH default, CNT_W = $clog2(WIDTH) constant, LSB_FIRST default. These are shared with the PISO and framing blocks.
- One natural sub-module: word_hold_reg, a WIDTH-bit valid/ready holding register with load, accept and drop/overrun logic.
- Shift register and counter stay in the top level.

Test Plan:
- Reset, then send 0xA5 as serial bits 1,0,1,0,0,1,0,1 with shift_in every cycle and data_ready=1 -> data_valid=1 for exactly one cycle after the 8th strobe, with data_out=0xA5.
- Send 0x3C with random 0-3 cycle gaps between strobes -> data_out=0x3C. bit_count is observed stepping 0..7 and holding during gaps.
- data_ready=0; send 0x11 then 0x22 back-to-back -> data_out stays 0x11 and overrun=1 after the 16th strobe. Then raise data_ready: 0x11 transfers, data_valid=0. Pulse ovr_clr: overrun=0.
- data_ready=0 until the edge where the 0x44 word completes, with 0x33 already held and ready=1 on that edge -> 0x33 transfers, data_out=0x44, data_valid stays 1, overrun=0.
- Send 3 bits, assert sync with shift_in=1 and serial_in=1, then 7 more bits of 0x81 -> data_out=0x81. A separate sync with shift_in=0 yields bit_count=0.
- Assert rst after 5 bits with data_valid=1 holding 0xFF -> all outputs 0 next cycle. A following full 0x5A word is received correctly. Repeat with LSB_FIRST=0: bits 0,1,0,1,1,0,1,0 -> 0x5A.
